// File: rtl/alu_issue.sv
// ALU issue/capture controller: registers operands and select into an external
// gate-level datapath, waits SETTLE cycles for it to settle, then presents the result.
module alu_issue #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_select,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic [2:0]       res_op
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_VALID} state_t;

    localparam logic [3:0] SettleLoad = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] aluA_q, aluA_d;
    logic [WIDTH-1:0] aluB_q, aluB_d;
    logic [2:0]       aluSel_q, aluSel_d;
    logic             resValid_q, resValid_d;
    logic [WIDTH-1:0] resData_q, resData_d;
    logic             resCarry_q, resCarry_d;
    logic             resZero_q, resZero_d;
    logic [2:0]       resOp_q, resOp_d;
    logic             accept;
    logic             capture;

    // Ready depends only on state and the consumer, so a draining result can
    // admit the next command on the same edge.
    always_comb begin
        cmd_ready = 1'b0;
        case (state_q)
            S_IDLE:   cmd_ready = 1'b1;
            S_VALID:  cmd_ready = res_ready;
            default:  cmd_ready = 1'b0;
        endcase
    end

    assign accept  = cmd_valid & cmd_ready;
    assign capture = (state_q == S_SETTLE) && (count_q == 4'd1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        aluA_d     = aluA_q;
        aluB_d     = aluB_q;
        aluSel_d   = aluSel_q;
        resData_d  = resData_q;
        resCarry_d = resCarry_q;
        resZero_d  = resZero_q;
        resOp_d    = resOp_q;

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                count_d = count_q - 4'd1;
                if (capture) state_d = S_VALID;
            end
            S_VALID: begin
                if (res_ready) state_d = accept ? S_SETTLE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            aluA_d   = cmd_a;
            aluB_d   = cmd_b;
            aluSel_d = cmd_op;
            count_d  = SettleLoad;
        end

        // Select is sampled from the register so res_op names the operation
        // actually present on the datapath.
        if (capture) begin
            resData_d  = alu_result;
            resCarry_d = alu_carry;
            resZero_d  = (alu_result == '0);
            resOp_d    = aluSel_q;
        end

        resValid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= 4'd0;
            aluA_q     <= '0;
            aluB_q     <= '0;
            aluSel_q   <= 3'd0;
            resValid_q <= 1'b0;
            resData_q  <= '0;
            resCarry_q <= 1'b0;
            resZero_q  <= 1'b0;
            resOp_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            aluA_q     <= aluA_d;
            aluB_q     <= aluB_d;
            aluSel_q   <= aluSel_d;
            resValid_q <= resValid_d;
            resData_q  <= resData_d;
            resCarry_q <= resCarry_d;
            resZero_q  <= resZero_d;
            resOp_q    <= resOp_d;
        end
    end

    assign alu_a      = aluA_q;
    assign alu_b      = aluB_q;
    assign alu_select = aluSel_q;
    assign res_valid  = resValid_q;
    assign res_data   = resData_q;
    assign res_carry  = resCarry_q;
    assign res_zero   = resZero_q;
    assign res_op     = resOp_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: three instances (SETTLE = 2, 1, 15) each
// driving a behavioural 4-bit datapath, checked against a command-level model.
module tb_alu_issue;

    logic       clk;
    logic       rst_n;
    logic [2:0] cmdOp;
    logic [3:0] cmdA;
    logic [3:0] cmdB;

    logic       cmdValid [3];
    logic       cmdReady [3];
    logic [3:0] aluA     [3];
    logic [3:0] aluB     [3];
    logic [2:0] aluSel   [3];
    logic [3:0] aluRes   [3];
    logic       aluCarry [3];
    logic       resValid [3];
    logic       resReady [3];
    logic [3:0] resData  [3];
    logic       resCarry [3];
    logic       resZero  [3];
    logic [2:0] resOp    [3];

    int checkCount;
    int passCount;

    // Datapath behaviour: returns {carry, result} for an opcode.
    function automatic logic [4:0] refAlu(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a[3], a[2:0], 1'b0};
            default: return {1'b0, b};
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gPath
        assign {aluCarry[g], aluRes[g]} = refAlu(aluSel[g], aluA[g], aluB[g]);
    end

    alu_issue dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmdValid[0]), .cmd_ready(cmdReady[0]),
        .cmd_op(cmdOp), .cmd_a(cmdA), .cmd_b(cmdB), .alu_a(aluA[0]), .alu_b(aluB[0]),
        .alu_select(aluSel[0]), .alu_result(aluRes[0]), .alu_carry(aluCarry[0]),
        .res_valid(resValid[0]), .res_ready(resReady[0]), .res_data(resData[0]),
        .res_carry(resCarry[0]), .res_zero(resZero[0]), .res_op(resOp[0])
    );

    alu_issue #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmdValid[1]), .cmd_ready(cmdReady[1]),
        .cmd_op(cmdOp), .cmd_a(cmdA), .cmd_b(cmdB), .alu_a(aluA[1]), .alu_b(aluB[1]),
        .alu_select(aluSel[1]), .alu_result(aluRes[1]), .alu_carry(aluCarry[1]),
        .res_valid(resValid[1]), .res_ready(resReady[1]), .res_data(resData[1]),
        .res_carry(resCarry[1]), .res_zero(resZero[1]), .res_op(resOp[1])
    );

    alu_issue #(.WIDTH(4), .SETTLE(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmdValid[2]), .cmd_ready(cmdReady[2]),
        .cmd_op(cmdOp), .cmd_a(cmdA), .cmd_b(cmdB), .alu_a(aluA[2]), .alu_b(aluB[2]),
        .alu_select(aluSel[2]), .alu_result(aluRes[2]), .alu_carry(aluCarry[2]),
        .res_valid(resValid[2]), .res_ready(resReady[2]), .res_data(resData[2]),
        .res_carry(resCarry[2]), .res_zero(resZero[2]), .res_op(resOp[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    // Present one command to instance d, let it be accepted, then wait
    // (bounded) for the result; lat is edges from accept to res_valid.
    task automatic applyStimulus(input int d, input logic [2:0] op, input logic [3:0] a,
                                 input logic [3:0] b, output int lat);
        int waitCyc;
        cmdOp = op;
        cmdA = a;
        cmdB = b;
        cmdValid[d] = 1'b1;
        waitCyc = 0;
        while (cmdReady[d] !== 1'b1 && waitCyc < 40) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        checkOutput("accept_ready", cmdReady[d], 1);
        @(posedge clk); #1;
        cmdValid[d] = 1'b0;
        lat = 0;
        while (resValid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int got;
        int sent;
        int cycle;
        int lastEdge;
        int pulses;
        bit acc;
        logic [2:0] rop;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [4:0] ex;
        logic [7:0] expQ[$];
        logic [7:0] head;
        logic [2:0] bOps [4];
        logic [3:0] bA   [4];
        logic [3:0] bB   [4];

        checkCount = 0;
        passCount  = 0;
        rst_n = 1'b0;
        cmdOp = 3'd0;
        cmdA  = 4'h0;
        cmdB  = 4'h0;
        for (int i = 0; i < 3; i++) begin
            cmdValid[i] = 1'b0;
            resReady[i] = 1'b1;
        end

        // Reset state, with a command offered that must not be taken.
        cmdValid[0] = 1'b1;
        cmdOp = 3'd4;
        cmdA  = 4'hA;
        cmdB  = 4'h6;
        #1;
        checkOutput("rst_res_valid", resValid[0], 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_no_accept_a", aluA[0], 0);
        checkOutput("rst_no_accept_sel", aluSel[0], 0);
        checkOutput("rst_res_data", resData[0], 0);
        checkOutput("rst_res_zero", resZero[0], 0);
        checkOutput("rst_valid15", resValid[2], 0);
        cmdValid[0] = 1'b0;
        rst_n = 1'b1;

        // Basic add, accepted on the first edge after reset release.
        applyStimulus(0, 3'd0, 4'h5, 4'h3, lat);
        checkOutput("add_latency", lat, 2);
        checkOutput("add_alu_a", aluA[0], 4'h5);
        checkOutput("add_alu_b", aluB[0], 4'h3);
        checkOutput("add_data", resData[0], 4'h8);
        checkOutput("add_carry", resCarry[0], 0);
        checkOutput("add_zero", resZero[0], 0);
        checkOutput("add_op", resOp[0], 0);
        @(posedge clk); #1;
        checkOutput("drain_valid", resValid[0], 0);
        checkOutput("drain_keep_data", resData[0], 4'h8);

        // Overflow to zero under backpressure: outputs must hold.
        resReady[0] = 1'b0;
        applyStimulus(0, 3'd0, 4'hF, 4'h1, lat);
        checkOutput("ovf_latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            cmdValid[0] = 1'b1;
            checkOutput("hold_valid", resValid[0], 1);
            checkOutput("hold_data", {resCarry[0], resZero[0], resData[0]}, 6'b11_0000);
            checkOutput("hold_cmd_ready", cmdReady[0], 0);
            @(posedge clk); #1;
        end
        cmdValid[0] = 1'b0;
        resReady[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("ovf_drain", resValid[0], 0);

        // Back-to-back commands with continuous cmd_valid.
        for (int i = 0; i < 4; i++) begin
            bOps[i] = 3'($urandom_range(0, 7));
            bA[i]   = 4'($urandom_range(0, 15));
            bB[i]   = 4'($urandom_range(0, 15));
        end
        sent = 0;
        got = 0;
        cycle = 0;
        lastEdge = 0;
        cmdOp = bOps[0];
        cmdA  = bA[0];
        cmdB  = bB[0];
        cmdValid[0] = 1'b1;
        while (got < 4 && cycle < 100) begin
            @(negedge clk);
            acc = cmdValid[0] && cmdReady[0];
            @(posedge clk); #1;
            cycle++;
            if (acc) begin
                ex = refAlu(cmdOp, cmdA, cmdB);
                expQ.push_back({cmdOp, ex});
                sent++;
                if (sent < 4) begin
                    cmdOp = bOps[sent];
                    cmdA  = bA[sent];
                    cmdB  = bB[sent];
                end else begin
                    cmdValid[0] = 1'b0;
                end
            end
            if (resValid[0] === 1'b1) begin
                head = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
                checkOutput("b2b_result", {resOp[0], resCarry[0], resData[0]}, head);
                if (got > 0) checkOutput("b2b_interval", cycle - lastEdge, 3);
                lastEdge = cycle;
                got++;
            end
        end
        checkOutput("b2b_count", got, 4);
        cmdValid[0] = 1'b0;
        @(posedge clk); #1;

        // Randomized commands with occasional one-cycle backpressure.
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            ex  = refAlu(rop, ra, rb);
            resReady[0] = 1'($urandom_range(0, 1));
            applyStimulus(0, rop, ra, rb, lat);
            checkOutput("rand_latency", lat, 2);
            checkOutput("rand_result", {resOp[0], resCarry[0], resZero[0], resData[0]},
                        {rop, ex[4], (ex[3:0] == 4'h0), ex[3:0]});
            if (resReady[0] == 1'b0) begin
                @(posedge clk); #1;
                checkOutput("rand_hold", {resValid[0], resData[0]}, {1'b1, ex[3:0]});
                resReady[0] = 1'b1;
            end
            @(posedge clk); #1;
            checkOutput("rand_drain", resValid[0], 0);
        end

        // Latency at the parameter extremes.
        applyStimulus(1, 3'd0, 4'h5, 4'h3, lat);
        checkOutput("s1_latency", lat, 1);
        checkOutput("s1_data", resData[1], 4'h8);
        applyStimulus(2, 3'd0, 4'h5, 4'h3, lat);
        checkOutput("s15_latency", lat, 15);
        checkOutput("s15_data", resData[2], 4'h8);
        @(posedge clk); #1;

        // Operand inputs toggling during SETTLE must not reach the datapath.
        rop = 3'd1;
        ra  = 4'h2;
        rb  = 4'h9;
        cmdOp = rop;
        cmdA  = ra;
        cmdB  = rb;
        cmdValid[2] = 1'b1;
        resReady[2] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            cmdOp = 3'($urandom_range(0, 7));
            cmdA  = 4'($urandom_range(0, 15));
            cmdB  = 4'($urandom_range(0, 15));
            checkOutput("settle_hold_alu", {aluSel[2], aluA[2], aluB[2]}, {rop, ra, rb});
            @(posedge clk); #1;
        end
        ex = refAlu(rop, ra, rb);
        checkOutput("settle_result", {resValid[2], resCarry[2], resData[2]}, {1'b1, ex});
        cmdValid[2] = 1'b0;
        resReady[2] = 1'b1;
        @(posedge clk); #1;
        checkOutput("settle_drain", resValid[2], 0);

        // Reset in the middle of SETTLE aborts the command.
        cmdOp = 3'd3;
        cmdA  = 4'hC;
        cmdB  = 4'h3;
        cmdValid[2] = 1'b1;
        @(posedge clk); #1;
        cmdValid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs",
                    {resValid[2], resData[2], resCarry[2], resZero[2], resOp[2],
                     aluA[2], aluB[2], aluSel[2]}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (resValid[2] === 1'b1) pulses++;
        end
        checkOutput("abort_no_result", pulses, 0);
        applyStimulus(2, 3'd2, 4'hE, 4'h7, lat);
        checkOutput("post_abort_latency", lat, 15);
        checkOutput("post_abort_data", {resOp[2], resData[2]}, {3'd2, 4'h6});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
